// File: rtl/sw_sel_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : sw_sel_seq_if
//  Description : Bus bundle between the G-bus decode (master) and the
//                switch-selector sequencer (slave). Carries the timing
//                enable, load/execute/clear strobes, the command and stage
//                select, and the register images and status flags.
//  Revision    : 1.0  initial release
// ============================================================================
interface sw_sel_seq_if #(
    parameter int CMD_W  = 8,
    parameter int STAGES = 4
) ();

    logic              V1;
    logic              SSRV;
    logic [CMD_W-1:0]  CMD;
    logic [STAGES-1:0] STG;
    logic              READ;
    logic              CLR;
    logic [CMD_W-1:0]  SSR;
    logic [CMD_W-1:0]  SSRN;
    logic [STAGES-1:0] STG_Q;
    logic              HELD;
    logic              FIRE;
    logic              ERR;

    // Decode side: drives strobes and data, observes the register images
    modport master (
        output V1, SSRV, CMD, STG, READ, CLR,
        input  SSR, SSRN, STG_Q, HELD, FIRE, ERR
    );

    // Sequencer side
    modport slave (
        input  V1, SSRV, CMD, STG, READ, CLR,
        output SSR, SSRN, STG_Q, HELD, FIRE, ERR
    );

endinterface
`default_nettype wire

// File: rtl/sw_sel_seq.sv
`default_nettype none
// ============================================================================
//  Module      : sw_sel_seq
//  Description : Switch-selector sequencer. Latches a command and a one-hot
//                stage select on SSRV, exposes true/complement images for
//                readback, then on READ drives a fire pulse lasting
//                READ_CYCLES V1-enabled cycles and self-clears.
//                Optional feature macro: SW_SEL_PARITY_EN -- when defined,
//                CMD[CMD_W-1] is an odd-parity bit over the whole CMD word
//                and loads with even parity are rejected.
//  Revision    : 1.0  initial release
// ============================================================================
module sw_sel_seq #(
    parameter int CMD_W       = 8,
    parameter int STAGES      = 4,
    parameter int READ_CYCLES = 16,
    parameter int CNT_W       = 8
) (
    input  wire logic     SIM_CLK,
    input  wire logic     SIM_RST,
    sw_sel_seq_if.slave   bus
);

    localparam logic [1:0] C_ST_IDLE = 2'd0;
    localparam logic [1:0] C_ST_HELD = 2'd1;
    localparam logic [1:0] C_ST_FIRE = 2'd2;

    // Counter preload: the pulse covers counts READ_CYCLES-1 down to 0
    localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(READ_CYCLES - 1);

    logic [1:0]        state_q, state_d;
    logic [CMD_W-1:0]  ssr_q,   ssr_d;
    logic [STAGES-1:0] stg_q,   stg_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              err_q,   err_d;

    logic              w_stg_onehot;
    logic              w_parity_ok;
    logic              w_load_ok;

    // Stage select must have exactly one bit set
    assign w_stg_onehot = (bus.STG != '0) &&
                          ((bus.STG & (bus.STG - STAGES'(1))) == '0);

`ifdef SW_SEL_PARITY_EN
    // Odd parity over the full word, parity bit included
    assign w_parity_ok = ^bus.CMD;
`else
    assign w_parity_ok = 1'b1;
`endif

    assign w_load_ok = w_stg_onehot && w_parity_ok;

    // State register: reset wins over everything, including V1
    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            state_q <= C_ST_IDLE;
            ssr_q   <= '0;
            stg_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ssr_q   <= ssr_d;
            stg_q   <= stg_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: only V1-enabled cycles advance; CLR > READ > SSRV
    always_comb begin
        state_d = state_q;
        ssr_d   = ssr_q;
        stg_d   = stg_q;
        cnt_d   = cnt_q;
        err_d   = err_q;

        if (bus.V1) begin
            if (bus.CLR) begin
                // Clear aborts any pending or active operation
                state_d = C_ST_IDLE;
                ssr_d   = '0;
                stg_d   = '0;
                cnt_d   = '0;
                err_d   = 1'b0;
            end else begin
                case (state_q)
                    C_ST_IDLE: begin
                        // READ with nothing held is silently ignored and
                        // takes precedence over a coincident SSRV
                        if (!bus.READ && bus.SSRV) begin
                            if (w_load_ok) begin
                                ssr_d   = bus.CMD;
                                stg_d   = bus.STG;
                                state_d = C_ST_HELD;
                            end else begin
                                err_d   = 1'b1;
                            end
                        end
                    end

                    C_ST_HELD: begin
                        if (bus.READ) begin
                            cnt_d   = C_CNT_LOAD;
                            state_d = C_ST_FIRE;
                        end else if (bus.SSRV) begin
                            // A held command is never overwritten
                            err_d   = 1'b1;
                        end
                    end

                    C_ST_FIRE: begin
                        if (bus.READ || bus.SSRV) begin
                            err_d = 1'b1;
                        end
                        if (cnt_q == '0) begin
                            // Last enabled cycle of the pulse: self-clear
                            ssr_d   = '0;
                            stg_d   = '0;
                            state_d = C_ST_IDLE;
                        end else begin
                            cnt_d   = cnt_q - CNT_W'(1);
                        end
                    end

                    default: begin
                        // Unreachable encoding: recover to a clean idle
                        state_d = C_ST_IDLE;
                        ssr_d   = '0;
                        stg_d   = '0;
                        cnt_d   = '0;
                    end
                endcase
            end
        end
    end

    // Output decode: status flags come from the state register only
    always_comb begin
        bus.SSR   = ssr_q;
        bus.SSRN  = ~ssr_q;
        bus.STG_Q = stg_q;
        bus.HELD  = (state_q == C_ST_HELD);
        bus.FIRE  = (state_q == C_ST_FIRE);
        bus.ERR   = err_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_sw_sel_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sw_sel_seq
//  Description : Scoreboard bench for sw_sel_seq. Stimulus updates a
//                behavioural model and queues the expected outputs for each
//                clock; an independent monitor compares after every edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sw_sel_seq;

    localparam int CMD_W       = 8;
    localparam int STAGES      = 4;
    localparam int READ_CYCLES = 16;
    localparam int CNT_W       = 8;

    typedef struct packed {
        logic [CMD_W-1:0]  ssr;
        logic [CMD_W-1:0]  ssrn;
        logic [STAGES-1:0] stg;
        logic              held;
        logic              fire;
        logic              err;
    } exp_t;

    logic SIM_CLK = 1'b0;
    logic SIM_RST = 1'b1;

    sw_sel_seq_if #(.CMD_W(CMD_W), .STAGES(STAGES)) bus ();

    sw_sel_seq #(
        .CMD_W       (CMD_W),
        .STAGES      (STAGES),
        .READ_CYCLES (READ_CYCLES),
        .CNT_W       (CNT_W)
    ) dut (
        .SIM_CLK (SIM_CLK),
        .SIM_RST (SIM_RST),
        .bus     (bus.slave)
    );

    always #5 SIM_CLK = ~SIM_CLK;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: a stored command, a "loaded" flag and a count of
    // enabled cycles left in the fire pulse (0 = not firing)
    logic [CMD_W-1:0]  m_cmd;
    logic [STAGES-1:0] m_stg;
    bit                m_loaded;
    int                m_left;
    bit                m_err;

    function automatic bit parity_ok(input logic [CMD_W-1:0] c);
`ifdef SW_SEL_PARITY_EN
        return ($countones(c) % 2) == 1;
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_step(input bit rst, input bit v1, input bit ssrv,
                              input logic [CMD_W-1:0] cmd,
                              input logic [STAGES-1:0] stg,
                              input bit rd, input bit clr);
        if (rst || (v1 && clr)) begin
            m_cmd = '0; m_stg = '0; m_loaded = 0; m_left = 0; m_err = 0;
        end else if (v1) begin
            if (m_left > 0) begin
                if (ssrv || rd) m_err = 1;
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_cmd = '0; m_stg = '0;
                end
            end else if (m_loaded) begin
                if (rd) begin
                    m_loaded = 0;
                    m_left   = READ_CYCLES;
                end else if (ssrv) begin
                    m_err = 1;
                end
            end else if (!rd && ssrv) begin
                if ($countones(stg) == 1 && parity_ok(cmd)) begin
                    m_cmd = cmd; m_stg = stg; m_loaded = 1;
                end else begin
                    m_err = 1;
                end
            end
        end
    endtask

    // Drive one clock of stimulus and queue what the outputs must be after it
    task automatic cyc(input bit rst, input bit v1, input bit ssrv,
                       input logic [CMD_W-1:0] cmd,
                       input logic [STAGES-1:0] stg,
                       input bit rd, input bit clr);
        exp_t e;
        @(negedge SIM_CLK);
        SIM_RST  = rst;
        bus.V1   = v1;
        bus.SSRV = ssrv;
        bus.CMD  = cmd;
        bus.STG  = stg;
        bus.READ = rd;
        bus.CLR  = clr;
        model_step(rst, v1, ssrv, cmd, stg, rd, clr);
        e.ssr  = m_cmd;
        e.ssrn = ~m_cmd;
        e.stg  = m_stg;
        e.held = m_loaded;
        e.fire = (m_left > 0);
        e.err  = m_err;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n, input bit v1);
        for (int i = 0; i < n; i++) cyc(0, v1, 0, '0, '0, 0, 0);
    endtask

    task automatic load(input logic [CMD_W-1:0] cmd, input logic [STAGES-1:0] stg);
        cyc(0, 1, 1, cmd, stg, 0, 0);
    endtask

    // Monitor: compares every field just after each rising edge
    always @(posedge SIM_CLK) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (bus.SSR !== e.ssr || bus.SSRN !== e.ssrn || bus.STG_Q !== e.stg ||
                bus.HELD !== e.held || bus.FIRE !== e.fire || bus.ERR !== e.err) begin
                bad++;
                $display("FAIL outputs @%0t: got ssr=%h ssrn=%h stg=%b held=%b fire=%b err=%b want ssr=%h ssrn=%h stg=%b held=%b fire=%b err=%b",
                         $time, bus.SSR, bus.SSRN, bus.STG_Q, bus.HELD, bus.FIRE, bus.ERR,
                         e.ssr, e.ssrn, e.stg, e.held, e.fire, e.err);
            end
        end
    end

    initial begin
        bus.V1 = 0; bus.SSRV = 0; bus.CMD = '0; bus.STG = '0;
        bus.READ = 0; bus.CLR = 0;
        m_cmd = '0; m_stg = '0; m_loaded = 0; m_left = 0; m_err = 0;

        // Reset, including with V1 low
        cyc(1, 0, 0, '0, '0, 0, 0);
        cyc(1, 1, 0, '0, '0, 0, 0);

        // Load, then a full pulse with V1 held high
        load(8'h5A, 4'b0010);
        idle(2, 1);
        cyc(0, 1, 0, '0, '0, 1, 0);
        idle(18, 1);

        // Same pulse with V1 toggling every other cycle
        load(8'h5A, 4'b0010);
        cyc(0, 1, 0, '0, '0, 1, 0);
        for (int i = 0; i < 40; i++) cyc(0, i[0], 0, '0, '0, 0, 0);

        // Non-one-hot stage select rejected, then CLR clears ERR
        load(8'h11, 4'b0110);
        idle(1, 1);
        cyc(0, 1, 0, '0, '0, 0, 1);

        // SSRV while held is ignored and flags an error
        load(8'h5A, 4'b0010);
        load(8'hFF, 4'b0001);
        idle(1, 0);

        // Abort a pulse with CLR on its fifth cycle
        cyc(0, 1, 0, '0, '0, 1, 0);
        idle(4, 1);
        cyc(0, 1, 0, '0, '0, 0, 1);
        idle(1, 1);

        // CLR, READ and SSRV together in HELD: clear wins
        load(8'h07, 4'b1000);
        cyc(0, 1, 1, 8'h33, 4'b0100, 1, 1);
        idle(1, 1);

        // Parity vectors (both load in the default build)
        load(8'h03, 4'b0001);
        cyc(0, 1, 0, '0, '0, 0, 1);
        load(8'h07, 4'b0001);
        cyc(0, 1, 0, '0, '0, 0, 1);

        // Back-to-back: reload on the first enabled cycle after FIRE drops
        load(8'h81, 4'b0100);
        cyc(0, 1, 0, '0, '0, 1, 0);
        idle(READ_CYCLES, 1);
        load(8'h7F, 4'b1000);
        cyc(0, 1, 0, '0, '0, 1, 0);
        cyc(0, 1, 1, 8'h01, 4'b0001, 0, 0);
        idle(READ_CYCLES, 1);

        // Randomised traffic; SSRV and READ never coincide
        for (int i = 0; i < 3000; i++) begin
            int op;
            logic [STAGES-1:0] s;
            op = $urandom_range(0, 5);
            if ($urandom_range(0, 3) != 0) s = STAGES'(1) << $urandom_range(0, STAGES - 1);
            else                           s = STAGES'($urandom);
            cyc(($urandom_range(0, 199) == 0),
                ($urandom_range(0, 3) != 0),
                (op == 1 || op == 2),
                CMD_W'($urandom),
                s,
                (op == 3),
                ($urandom_range(0, 39) == 0));
        end

        idle(2, 1);
        repeat (4) @(posedge SIM_CLK);
        #2;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
